// File: rtl/div_ctrl.sv
// Restoring divide sequencer for DIV/DIVU; result 33 cycles after start, and stall is held throughout. Optional DIV_ZERO_FAST_EN skips the iterations on a zero divisor.
// cancel aborts with no HI/LO write. hi/lo are registered and show the result in the hilo_we cycle.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] prv_hi_q, prv_hi_d;
    logic [WIDTH-1:0] prv_lo_q, prv_lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sh, diff;
    logic [WIDTH-1:0] step_rem, step_quo;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prv_hi_d = prv_hi_q;
        prv_lo_d = prv_lo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        stall    = 1'b0;
        hilo_we  = 1'b0;

        accept = start & ~cancel;
        mag_a  = (is_signed & opa[WIDTH-1]) ? -opa : opa;
        mag_b  = (is_signed & opb[WIDTH-1]) ? -opb : opb;

        // One restoring step: shift the dividend MSB into the remainder, trial-subtract.
        sh       = {rem_q, quo_q[WIDTH-1]};
        diff     = sh - {1'b0, dvs_q};
        step_rem = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        case (state_q)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    rem_d   = '0;
                    quo_d   = mag_a;
                    dvs_d   = mag_b;
                    qneg_d  = is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    rneg_d  = is_signed & opa[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (opb == '0) begin
                        state_d  = DONE;
                        prv_hi_d = hi_q;
                        prv_lo_d = lo_q;
                        hi_d     = opa;
                        lo_d     = '1;
                    end
`endif
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Result lands in hi/lo entering DONE; the committed pair is kept for a DONE cancel.
                        state_d  = DONE;
                        prv_hi_d = hi_q;
                        prv_lo_d = lo_q;
                        hi_d     = rneg_q ? -step_rem : step_rem;
                        lo_d     = qneg_q ? -step_quo : step_quo;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (cancel) begin
                    hi_d = prv_hi_q;
                    lo_d = prv_lo_q;
                end else begin
                    hilo_we = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (rst) begin
            hilo_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            prv_hi_q <= '0;
            prv_lo_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            prv_hi_q <= prv_hi_d;
            prv_lo_q <= prv_lo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the EX stage of the MIPS pipeline. Accepts a DIV/DIVU issue from the controller, holds the pipeline with `stall` while a 32-iteration restoring divider runs, then pulses a single HI/LO write. It owns the divider datapath and its FSM, and honours exception flushes at any point. The ALU path is untouched; this block sits beside the ALU and feeds the HI/LO register file.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EX holds a DIV/DIVU; level, held while stalled.
- `is_signed`  in  1  1 = DIV, 0 = DIVU; sampled with `start`.
- `opa`  in  WIDTH  dividend (rs); sampled with `start`.
- `opb`  in  WIDTH  divisor (rt); sampled with `start`.
- `cancel`  in  1  flush from exception logic; aborts the current divide.
- `stall`  out  1  combinational pipeline hold request.
- `busy`  out  1  registered; high in RUN and DONE.
- `hilo_we`  out  1  one-cycle HI/LO write strobe.
- `hi`  out  WIDTH  remainder; registered.
- `lo`  out  WIDTH  quotient; registered.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE, counter 0, `hi`=`lo`=0, `busy`=0, `hilo_we`=0.
- IDLE: `start`=1 and `cancel`=0 -> latch |opa|, |opb|, quotient sign (`is_signed` & (opa[MSB]^opb[MSB])), remainder sign (`is_signed` & opa[MSB]) -> RUN, counter 0. For unsigned operation, magnitudes are the raw operands.
- RUN: each cycle performs one restoring step, shifting the remainder/quotient pair left by one. If the trial subtraction is non-negative, keep the difference and set the quotient LSB to 1. Counter increments. When counter = WIDTH-1 -> DONE.
- DONE: apply sign fix (two's-complement negate on the quotient and/or remainder) and load `hi`/`lo`. Assert `hilo_we` for this cycle only -> IDLE. `start` is ignored in DONE, because the issuing instruction is still presented that cycle.
- `stall` = (IDLE & `start` & ~`cancel`) | RUN. It is low in DONE so the instruction leaves EX at the end of the DONE cycle.
- `cancel` in RUN: go to IDLE next edge, with no write. `stall` drops in the same cycle. `hi`/`lo` keep their old values.
- `cancel` in DONE: `hilo_we` forced 0, `hi`/`lo` not updated, -> IDLE.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): `lo`=0x80000000, `hi`=0. No trap.
- Divide by zero: restoring result, quotient magnitude 0xFFFFFFFF, remainder magnitude = |opa|, then sign fix. Software treats this as unpredictable.
- `hi`/`lo` hold the last written result indefinitely.

## Timing
- `start` rises in cycle 0. RUN covers cycles 1..32, DONE is cycle 33.
- `stall` is high in cycles 0..32 (33 cycles). `hilo_we`, `hi` and `lo` are valid in cycle 33.
- Back-to-back divides: the next `start` is accepted in IDLE at the earliest, cycle 34.
- `rst` in any state -> IDLE on that edge. All outputs return to reset values, and there is no partial HI/LO write.
- `cancel` together with `start` in IDLE: the request is not accepted, `stall`=0, and the block stays IDLE.

## Configuration
- `DIV_ZERO_FAST_EN` defined: in IDLE, `start` with `opb`=0 goes straight to DONE. DONE writes `hi`=`opa` and `lo`=0xFFFFFFFF regardless of sign. `stall` is high for cycle 0 only, and `hilo_we` pulses in cycle 1.
- `DIV_ZERO_FAST_EN` not defined: divide by zero runs the full 32 iterations with the timing above; results follow the algorithm.

## Test plan
- DIVU 100 / 7 -> `stall` high cycles 0..32; cycle 33: `hilo_we`=1, `lo`=14, `hi`=2.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIV 7 / -2 -> `lo`=-3, `hi`=1.
- DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, with no hang.
- `cancel` at cycle 10 of RUN -> `stall` low in cycle 10, IDLE next, `hilo_we` never pulses, `hi`/`lo` unchanged. `rst` at cycle 20 -> all outputs 0 the next cycle.
- `start` held high through DONE -> exactly one `hilo_we`. A new `start` at cycle 34 begins a second divide.
- DIVU 5 / 0: with `DIV_ZERO_FAST_EN`, `hilo_we` at cycle 1 with `hi`=5, `lo`=0xFFFFFFFF. Without it, `hilo_we` at cycle 33 with the same values.
